stage_if: RTL and testbench

Instruction fetch stage of the five-stage pipelined MIPS core. It is the producer side of the IF/ID interface: it holds the program counter, reads a word-addressed instruction memory, and registers the fetched instruction and PC+4 into the IF/ID pipeline register that the decode stage consumes. It accepts stall, flush and branch/jump redirect controls fed back from decode and hazard logic, and provides a loader write port for filling instruction memory before or during a run.

---
 rtl/stage_if.sv | 102 ++++++++++
 tb/tb_stage_if.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stage_if.sv
// rtl/stage_if.sv - MIPS instruction fetch stage driving the IF/ID pipeline register
//
// Holds the program counter, reads a word-addressed instruction memory
// combinationally and registers {instruction, pc_plus4, valid} for decode.
//
// Ports:
//   clock, reset_n                 rising-edge clock, asynchronous active-low reset
//   stall                          hold PC and IF/ID
//   flush                          load a bubble into IF/ID
//   branch_taken, branch_target    taken branch from decode (byte address)
//   jump, jump_index               unconditional jump from decode
//   imem_wr_en/addr/data           loader write port (word index)
//   instruction, pc_plus4, valid   IF/ID register outputs
//   pc                             current fetch PC

module stage_if #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        imem_wr_en,
    input  logic [31:0] imem_wr_addr,
    input  logic [31:0] imem_wr_data,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus4,
    output logic        valid,
    output logic [31:0] pc
);

    localparam int          AW      = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam logic [30:0] DEPTH31 = 31'(IMEM_DEPTH);

    // Contents survive reset so a program loaded before reset release stays put.
    logic [31:0] mem [IMEM_DEPTH];

    logic [29:0] word_idx;
    logic        in_range;
    logic [31:0] fetch_word;
    logic [31:0] pc_next4;
    logic        redirect;
    logic [31:0] redirect_target;

    // Address bits beyond the memory and the byte offset of the branch target
    // are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{imem_wr_addr[31:AW], branch_target[1:0]};

    assign word_idx   = pc[31:2];
    assign in_range   = ({1'b0, word_idx} < DEPTH31);
    // Fetches outside the populated memory return a NOP rather than aliasing.
    assign fetch_word = in_range ? mem[word_idx[AW-1:0]] : 32'h00000000;
    assign pc_next4   = pc + 32'd4;

    assign redirect = jump | branch_taken;

    // The jump region comes from the IF/ID pc_plus4, which belongs to the jump
    // instruction sitting in decode. Jump outranks a simultaneous branch.
    assign redirect_target = jump ? {pc_plus4[31:28], jump_index, 2'b00}
                                  : {branch_target[31:2], 2'b00};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            instruction <= 32'h00000000;
            pc_plus4    <= 32'h00000000;
            valid       <= 1'b0;
        end else begin
            if (redirect) begin
                pc <= redirect_target;
            end else if (!stall) begin
                pc <= pc_next4;
            end

            // A bubble wins over stall so a stalled+flushed slot is cleared.
            if (redirect || flush) begin
                instruction <= 32'h00000000;
                pc_plus4    <= 32'h00000000;
                valid       <= 1'b0;
            end else if (!stall) begin
                instruction <= fetch_word;
                pc_plus4    <= pc_next4;
                valid       <= 1'b1;
            end
        end
    end

    // Loader write: a write to the word being fetched on the same edge lets
    // IF/ID capture the old word, the new one is seen by later fetches.
    always_ff @(posedge clock) begin
        if (imem_wr_en) begin
            mem[imem_wr_addr[AW-1:0]] <= imem_wr_data;
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// tb/tb_stage_if.sv - self-checking bench for stage_if

module tb_stage_if;

    localparam int          DEPTH = 256;
    localparam logic [31:0] RPC   = 32'h00000000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall, flush, branch_taken, jump, imem_wr_en;
    logic [31:0] branch_target, imem_wr_addr, imem_wr_data;
    logic [25:0] jump_index;
    logic [31:0] instruction, pc_plus4, pc;
    logic        valid;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] mem_m [DEPTH];
    logic [31:0] pc_m, instr_m, ppc_m;
    logic        valid_m;

    stage_if #(.IMEM_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .imem_wr_en    (imem_wr_en),
        .imem_wr_addr  (imem_wr_addr),
        .imem_wr_data  (imem_wr_data),
        .instruction   (instruction),
        .pc_plus4      (pc_plus4),
        .valid         (valid),
        .pc            (pc)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pc_m = RPC; instr_m = 0; ppc_m = 0; valid_m = 0;
    endtask

    // One clock edge of the fetch stage, written from the spec rules.
    task automatic model_edge();
        logic [31:0] word, fetched, target;
        word    = pc_m / 4;
        fetched = (word < DEPTH) ? mem_m[word] : 32'h0;
        if (reset_n) begin
            target = jump ? ((ppc_m & 32'hF000_0000) | ({6'd0, jump_index} * 4))
                          : (branch_target & 32'hFFFF_FFFC);
            if (jump || branch_taken || flush) begin
                instr_m = 0; ppc_m = 0; valid_m = 0;
            end else if (!stall) begin
                instr_m = fetched; ppc_m = pc_m + 4; valid_m = 1;
            end
            if (jump || branch_taken) pc_m = target;
            else if (!stall)          pc_m = pc_m + 4;
        end
        if (imem_wr_en) mem_m[imem_wr_addr % DEPTH] = imem_wr_data;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    pc,                 pc_m);
        chk({tag, ".instr"}, instruction,        instr_m);
        chk({tag, ".ppc4"},  pc_plus4,           ppc_m);
        chk({tag, ".valid"}, {31'd0, valid},     {31'd0, valid_m});
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic do_branch(input logic [31:0] tgt, input string tag);
        branch_taken = 1; branch_target = tgt;
        tick(tag);
        branch_taken = 0;
    endtask

    logic [31:0] saved;

    initial begin
        reset_n = 0; stall = 0; flush = 0; branch_taken = 0; jump = 0;
        branch_target = 0; jump_index = 0;
        imem_wr_en = 0; imem_wr_addr = 0; imem_wr_data = 0;
        model_reset();
        #1;
        check_all("reset");

        // Fill memory through the loader while reset is held
        for (int i = 0; i < DEPTH; i++) begin
            imem_wr_en   = 1;
            imem_wr_addr = i;
            case (i)
                0:       imem_wr_data = 32'h20010005;
                1:       imem_wr_data = 32'h20020003;
                2:       imem_wr_data = 32'h00221820;
                3:       imem_wr_data = 32'hAC030000;
                16:      imem_wr_data = 32'h8C040010;
                default: imem_wr_data = $urandom;
            endcase
            tick("load");
        end
        imem_wr_en = 0;
        chk("load.held_pc", pc, RPC);

        // Sequential fetch with a 3-cycle stall after the second word
        reset_n = 1;
        tick("seq0");
        chk("seq0.instr_c", instruction, 32'h20010005);
        chk("seq0.ppc_c",   pc_plus4,    32'd4);
        tick("seq1");
        chk("seq1.instr_c", instruction, 32'h20020003);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick("stall");
            chk("stall.instr_c", instruction, 32'h20020003);
            chk("stall.ppc_c",   pc_plus4,    32'd8);
            chk("stall.pc_c",    pc,          32'd8);
        end
        stall = 0;
        tick("seq2");
        chk("seq2.instr_c", instruction, 32'h00221820);
        chk("seq2.ppc_c",   pc_plus4,    32'd12);
        tick("seq3");
        chk("seq3.instr_c", instruction, 32'hAC030000);
        chk("seq3.ppc_c",   pc_plus4,    32'd16);

        // Branch redirect with unaligned target
        do_branch(32'h00000043, "br");
        chk("br.valid_c", {31'd0, valid}, 32'd0);
        chk("br.pc_c",    pc,             32'h40);
        tick("br_tgt");
        chk("br_tgt.instr_c", instruction, 32'h8C040010);
        chk("br_tgt.ppc_c",   pc_plus4,    32'h44);

        // Jump beats simultaneous branch
        do_branch(32'h10000004, "jsetup");
        tick("jsetup2");
        chk("jsetup.ppc_c", pc_plus4, 32'h10000008);
        jump = 1; jump_index = 26'h20; branch_taken = 1; branch_target = 32'h200;
        tick("jump");
        jump = 0; branch_taken = 0;
        chk("jump.pc_c",    pc,             32'h10000080);
        chk("jump.valid_c", {31'd0, valid}, 32'd0);
        tick("jump_tgt");
        chk("jump_tgt.ppc_c", pc_plus4, 32'h10000084);

        // Out-of-range fetch returns NOP but still valid
        do_branch(32'(4 * DEPTH), "oor");
        tick("oor2");
        chk("oor.instr_c", instruction,    32'd0);
        chk("oor.valid_c", {31'd0, valid}, 32'd1);

        // Write/read collision at the fetch PC
        do_branch(32'h20, "col");
        saved = mem_m[8];
        imem_wr_en = 1; imem_wr_addr = 32'hFFFF_FF08; imem_wr_data = 32'hDEADBEEF;
        tick("col_edge");
        imem_wr_en = 0;
        chk("col.old_c", instruction, saved);
        do_branch(32'h20, "col_re");
        tick("col_new");
        chk("col.new_c", instruction, 32'hDEADBEEF);

        // Stall and flush together: PC holds, bubble enters
        saved = pc;
        stall = 1; flush = 1;
        tick("stfl");
        stall = 0; flush = 0;
        chk("stfl.pc_c",    pc,             saved);
        chk("stfl.valid_c", {31'd0, valid}, 32'd0);

        // PC wrap at top of address space
        do_branch(32'hFFFFFFFC, "wrap");
        tick("wrap2");
        chk("wrap.pc_c",   pc,       32'd0);
        chk("wrap.ppc_c",  pc_plus4, 32'd0);

        // Randomized control traffic against the model
        for (int i = 0; i < 400; i++) begin
            stall         = ($urandom % 4) == 0;
            flush         = ($urandom % 8) == 0;
            branch_taken  = ($urandom % 10) == 0;
            jump          = ($urandom % 16) == 0;
            branch_target = $urandom % 1100;
            jump_index    = 26'($urandom % 300);
            imem_wr_en    = ($urandom % 5) == 0;
            imem_wr_addr  = $urandom;
            imem_wr_data  = $urandom;
            tick("rand");
        end
        stall = 0; flush = 0; branch_taken = 0; jump = 0; imem_wr_en = 0;

        // Asynchronous reset in the middle of a stall
        do_branch(32'h8, "rst_pre");
        tick("rst_pre2");
        stall = 1;
        tick("rst_stall");
        #2;
        reset_n = 0;
        #1;
        model_reset();
        chk("areset.pc_c",    pc,             RPC);
        chk("areset.instr_c", instruction,    32'd0);
        chk("areset.ppc_c",   pc_plus4,       32'd0);
        chk("areset.valid_c", {31'd0, valid}, 32'd0);
        stall = 0;
        tick("rst_hold");
        reset_n = 1;
        tick("rst_rel");
        chk("rst_rel.pc_c", pc, RPC + 4);
        tick("rst_rel2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
